// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multi-cycle controller: opcodes, FSM states,
// ALUOp classes and ALU operand mux encodings.
package multicycle_controller_pkg;

    localparam logic [6:0] OpR     = 7'b0110011;
    localparam logic [6:0] OpI     = 7'b0010011;
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpBeq   = 7'b1100011;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb
    } state_e;

    typedef enum logic [1:0] {
        AluAdd   = 2'b00,
        AluAddr  = 2'b01,
        AluFunct = 2'b10,
        AluSub   = 2'b11
    } alu_op_e;

    localparam logic       SrcAPc   = 1'b0;
    localparam logic       SrcARs1  = 1'b1;
    localparam logic [1:0] SrcBRs2  = 2'b00;
    localparam logic [1:0] SrcBFour = 2'b01;
    localparam logic [1:0] SrcBImm  = 2'b10;

    typedef struct packed {
        logic is_r;
        logic is_i;
        logic is_ld;
        logic is_st;
        logic is_br;
        logic legal;
    } op_class_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory bundle: IR opcode, ALU flag, memory ready in;
// enables, mux selects and status out.
interface multicycle_controller_if #(
    parameter int unsigned ALUOP_W = 2,
    parameter int unsigned CNT_W   = 32
);
    logic [6:0]         Opcode;
    logic               zero;
    logic               mem_ready;
    logic               PCWrite;
    logic               IRWrite;
    logic               IorD;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [ALUOP_W-1:0] ALUOp;
    logic               MemRead;
    logic               MemWrite;
    logic               MemtoReg;
    logic               RegWrite;
    logic               illegal;
    logic               mem_fault;
    logic [CNT_W-1:0]   instret;

    modport master (
        input  Opcode, zero, mem_ready,
        output PCWrite, IRWrite, IorD, ALUSrcA, ALUSrcB, ALUOp, MemRead, MemWrite,
               MemtoReg, RegWrite, illegal, mem_fault, instret
    );

    modport slave (
        output Opcode, zero, mem_ready,
        input  PCWrite, IRWrite, IorD, ALUSrcA, ALUSrcB, ALUOp, MemRead, MemWrite,
               MemtoReg, RegWrite, illegal, mem_fault, instret
    );
endinterface

// File: rtl/multicycle_controller_opcode_classifier.sv
// Combinational opcode decode into instruction classes plus a legality flag.
module opcode_classifier
    import multicycle_controller_pkg::*;
#(
    parameter bit EN_BRANCH = 1'b1
) (
    input  logic [6:0] opcode_i,
    output op_class_t  cls_o
);

    // Decode the opcode; BEQ is only recognised when branching is enabled
    always_comb begin
        cls_o = '0;
        case (opcode_i)
            OpR:     cls_o.is_r  = 1'b1;
            OpI:     cls_o.is_i  = 1'b1;
            OpLoad:  cls_o.is_ld = 1'b1;
            OpStore: cls_o.is_st = 1'b1;
            OpBeq:   cls_o.is_br = EN_BRANCH;
            default: ;
        endcase
        cls_o.legal = cls_o.is_r | cls_o.is_i | cls_o.is_ld | cls_o.is_st | cls_o.is_br;
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle main controller: FETCH/DECODE/EXEC/MEM/WB sequencer with memory
// wait timeout, illegal-opcode pulse and retired-instruction counter.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int unsigned ALUOP_W     = 2,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter bit          EN_BRANCH   = 1'b1
) (
    input logic                     clk,
    input logic                     reset,
    multicycle_controller_if.master bus_io
);

    localparam int unsigned WaitW = 32;

    state_e             state_q, state_d;
    logic [WaitW-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    op_class_t          cls;

    logic       pc_write, ir_write, iord, src_a, mem_read, mem_write;
    logic       mem_to_reg, reg_write, illegal, mem_fault, retire, timeout;
    logic [1:0] src_b;
    alu_op_e    alu_op;

    opcode_classifier #(
        .EN_BRANCH (EN_BRANCH)
    ) u_classifier (
        .opcode_i (bus_io.Opcode),
        .cls_o    (cls)
    );

    // Next state, Moore output decode gated by mem_ready/zero, wait and retire counters
    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        src_a      = SrcAPc;
        src_b      = SrcBRs2;
        alu_op     = AluAdd;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        mem_fault  = 1'b0;
        retire     = 1'b0;
        timeout    = (TIMEOUT_CYC != 0) && (wait_q == WaitW'(TIMEOUT_CYC));

        unique case (state_q)
            StFetch: begin
                mem_read = 1'b1;
                src_b    = SrcBFour;
                if (bus_io.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end else if (timeout) begin
                    mem_read  = 1'b0;
                    mem_fault = 1'b1;
                end
            end
            StDecode: begin
                // Branch target computed speculatively into ALUOut
                src_b = SrcBImm;
                if (cls.legal) begin
                    state_d = StExec;
                end else begin
                    illegal = 1'b1;
                    state_d = StFetch;
                end
            end
            StExec: begin
                src_a   = SrcARs1;
                state_d = StFetch;
                if (cls.is_r) begin
                    alu_op  = AluFunct;
                    state_d = StWb;
                end else if (cls.is_i) begin
                    src_b   = SrcBImm;
                    state_d = StWb;
                end else if (cls.is_ld || cls.is_st) begin
                    src_b   = SrcBImm;
                    alu_op  = AluAddr;
                    state_d = StMem;
                end else if (cls.is_br) begin
                    alu_op   = AluSub;
                    pc_write = bus_io.zero;
                    retire   = 1'b1;
                end
            end
            StMem: begin
                iord      = 1'b1;
                mem_read  = cls.is_ld;
                mem_write = cls.is_st;
                if (!(cls.is_ld || cls.is_st)) begin
                    state_d = StFetch;
                end else if (bus_io.mem_ready) begin
                    if (cls.is_ld) begin
                        state_d = StWb;
                    end else begin
                        retire  = 1'b1;
                        state_d = StFetch;
                    end
                end else if (timeout) begin
                    mem_read  = 1'b0;
                    mem_write = 1'b0;
                    mem_fault = 1'b1;
                    state_d   = StFetch;
                end
            end
            StWb: begin
                reg_write  = 1'b1;
                mem_to_reg = cls.is_ld;
                retire     = 1'b1;
                state_d    = StFetch;
            end
            default: state_d = StFetch;
        endcase

        // Counts only while a request is outstanding; any exit or fault clears it
        if (((state_q == StFetch) || (state_q == StMem)) && (mem_read || mem_write)
            && !bus_io.mem_ready) begin
            wait_d = wait_q + 1'b1;
        end else begin
            wait_d = '0;
        end

        instret_d = retire ? instret_q + 1'b1 : instret_q;
    end

    // State, wait counter and retire counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StFetch;
            wait_q    <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
        end
    end

    // All outputs forced low while reset is held so no write fires in the reset cycle
    assign bus_io.PCWrite   = pc_write & ~reset;
    assign bus_io.IRWrite   = ir_write & ~reset;
    assign bus_io.IorD      = iord & ~reset;
    assign bus_io.ALUSrcA   = src_a & ~reset;
    assign bus_io.ALUSrcB   = reset ? 2'b00 : src_b;
    assign bus_io.ALUOp     = reset ? '0 : ALUOP_W'(alu_op);
    assign bus_io.MemRead   = mem_read & ~reset;
    assign bus_io.MemWrite  = mem_write & ~reset;
    assign bus_io.MemtoReg  = mem_to_reg & ~reset;
    assign bus_io.RegWrite  = reg_write & ~reset;
    assign bus_io.illegal   = illegal & ~reset;
    assign bus_io.mem_fault = mem_fault & ~reset;
    assign bus_io.instret   = reset ? '0 : instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: the stimulus process pushes the expected per-cycle output
// vector; a negedge monitor pops and compares it against the DUT.
module tb_multicycle_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    multicycle_controller_if #(.ALUOP_W(2), .CNT_W(32)) bus ();

    multicycle_controller #(
        .ALUOP_W     (2),
        .CNT_W       (32),
        .TIMEOUT_CYC (4),
        .EN_BRANCH   (1'b1)
    ) dut (
        .clk    (clk),
        .reset  (rst),
        .bus_io (bus)
    );

    // ctl = {PCWrite,IRWrite,IorD,ALUSrcA,ALUSrcB[1:0],ALUOp[1:0],
    //        MemRead,MemWrite,MemtoReg,RegWrite,illegal,mem_fault}
    localparam logic [13:0] ZERO        = 14'b0_0_0_0_00_00_0_0_0_0_0_0;
    localparam logic [13:0] FETCH_RDY   = 14'b1_1_0_0_01_00_1_0_0_0_0_0;
    localparam logic [13:0] FETCH_WAIT  = 14'b0_0_0_0_01_00_1_0_0_0_0_0;
    localparam logic [13:0] FETCH_FLT   = 14'b0_0_0_0_01_00_0_0_0_0_0_1;
    localparam logic [13:0] DECODE      = 14'b0_0_0_0_10_00_0_0_0_0_0_0;
    localparam logic [13:0] DECODE_ILL  = 14'b0_0_0_0_10_00_0_0_0_0_1_0;
    localparam logic [13:0] EXEC_R      = 14'b0_0_0_1_00_10_0_0_0_0_0_0;
    localparam logic [13:0] EXEC_I      = 14'b0_0_0_1_10_00_0_0_0_0_0_0;
    localparam logic [13:0] EXEC_LS     = 14'b0_0_0_1_10_01_0_0_0_0_0_0;
    localparam logic [13:0] EXEC_BEQ_T  = 14'b1_0_0_1_00_11_0_0_0_0_0_0;
    localparam logic [13:0] EXEC_BEQ_N  = 14'b0_0_0_1_00_11_0_0_0_0_0_0;
    localparam logic [13:0] MEM_LD      = 14'b0_0_1_0_00_00_1_0_0_0_0_0;
    localparam logic [13:0] MEM_ST      = 14'b0_0_1_0_00_00_0_1_0_0_0_0;
    localparam logic [13:0] MEM_FLT     = 14'b0_0_1_0_00_00_0_0_0_0_0_1;
    localparam logic [13:0] WB_LD       = 14'b0_0_0_0_00_00_0_0_1_1_0_0;
    localparam logic [13:0] WB_ALU      = 14'b0_0_0_0_00_00_0_0_0_1_0_0;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1110011;

    logic [45:0] exp_q[$];
    string       name_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    // Drive one cycle of inputs and queue the output vector expected for it
    task automatic step(input logic r, input logic [6:0] op, input logic z, input logic rdy,
                        input logic [13:0] ctl, input int unsigned ir, input string nm);
        rst           = r;
        bus.Opcode    = op;
        bus.zero      = z;
        bus.mem_ready = rdy;
        exp_q.push_back({ctl, ir});
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every cycle that has a queued expectation
    always @(negedge clk) begin
        logic [45:0] act;
        logic [45:0] e;
        string       nm;
        if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = {bus.PCWrite, bus.IRWrite, bus.IorD, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
                   bus.MemRead, bus.MemWrite, bus.MemtoReg, bus.RegWrite, bus.illegal,
                   bus.mem_fault, bus.instret};
            n_vec++;
            if (act !== e) begin
                n_err++;
                $display("FAIL %s: got ctl=%b instret=%0d, expected ctl=%b instret=%0d",
                         nm, act[45:32], act[31:0], e[45:32], e[31:0]);
            end
        end
    end

    initial begin
        bus.Opcode    = OP_R;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;

        repeat (3) step(1'b1, OP_R, 1'b0, 1'b1, ZERO, 0, "reset_hold");

        // R-type, zero-wait
        step(1'b0, OP_R, 1'b0, 1'b1, FETCH_RDY, 0, "r_fetch");
        step(1'b0, OP_R, 1'b0, 1'b1, DECODE,    0, "r_decode");
        step(1'b0, OP_R, 1'b0, 1'b1, EXEC_R,    0, "r_exec");
        step(1'b0, OP_R, 1'b0, 1'b1, WB_ALU,    0, "r_wb");

        // LOAD with three wait cycles in MEM
        step(1'b0, OP_LD, 1'b0, 1'b1, FETCH_RDY, 1, "ld_fetch");
        step(1'b0, OP_LD, 1'b0, 1'b1, DECODE,    1, "ld_decode");
        step(1'b0, OP_LD, 1'b0, 1'b1, EXEC_LS,   1, "ld_exec");
        repeat (3) step(1'b0, OP_LD, 1'b0, 1'b0, MEM_LD, 1, "ld_mem_wait");
        step(1'b0, OP_LD, 1'b0, 1'b1, MEM_LD,    1, "ld_mem_done");
        step(1'b0, OP_LD, 1'b0, 1'b1, WB_LD,     1, "ld_wb");

        // BEQ taken then not taken
        step(1'b0, OP_BEQ, 1'b1, 1'b1, FETCH_RDY,  2, "beq_t_fetch");
        step(1'b0, OP_BEQ, 1'b1, 1'b1, DECODE,     2, "beq_t_decode");
        step(1'b0, OP_BEQ, 1'b1, 1'b1, EXEC_BEQ_T, 2, "beq_t_exec");
        step(1'b0, OP_BEQ, 1'b0, 1'b1, FETCH_RDY,  3, "beq_n_fetch");
        step(1'b0, OP_BEQ, 1'b0, 1'b1, DECODE,     3, "beq_n_decode");
        step(1'b0, OP_BEQ, 1'b0, 1'b1, EXEC_BEQ_N, 3, "beq_n_exec");

        // I-type
        step(1'b0, OP_I, 1'b0, 1'b1, FETCH_RDY, 4, "i_fetch");
        step(1'b0, OP_I, 1'b0, 1'b1, DECODE,    4, "i_decode");
        step(1'b0, OP_I, 1'b0, 1'b1, EXEC_I,    4, "i_exec");
        step(1'b0, OP_I, 1'b0, 1'b1, WB_ALU,    4, "i_wb");

        // STORE, zero-wait
        step(1'b0, OP_ST, 1'b0, 1'b1, FETCH_RDY, 5, "st_fetch");
        step(1'b0, OP_ST, 1'b0, 1'b1, DECODE,    5, "st_decode");
        step(1'b0, OP_ST, 1'b0, 1'b1, EXEC_LS,   5, "st_exec");
        step(1'b0, OP_ST, 1'b0, 1'b1, MEM_ST,    5, "st_mem");

        // Illegal opcode: pulse in DECODE, no retire
        step(1'b0, OP_BAD, 1'b0, 1'b1, FETCH_RDY,  6, "ill_fetch");
        step(1'b0, OP_BAD, 1'b0, 1'b1, DECODE_ILL, 6, "ill_decode");

        // STORE with memory stuck: four waits then fault, no retire
        step(1'b0, OP_ST, 1'b0, 1'b1, FETCH_RDY, 6, "sto_fetch");
        step(1'b0, OP_ST, 1'b0, 1'b1, DECODE,    6, "sto_decode");
        step(1'b0, OP_ST, 1'b0, 1'b1, EXEC_LS,   6, "sto_exec");
        repeat (4) step(1'b0, OP_ST, 1'b0, 1'b0, MEM_ST, 6, "sto_mem_wait");
        step(1'b0, OP_ST, 1'b0, 1'b0, MEM_FLT,   6, "sto_fault");

        // Instruction fetch stuck: fault from FETCH, stays in FETCH
        repeat (4) step(1'b0, OP_ST, 1'b0, 1'b0, FETCH_WAIT, 6, "fto_wait");
        step(1'b0, OP_ST, 1'b0, 1'b0, FETCH_FLT, 6, "fto_fault");

        // STORE where mem_ready arrives exactly at the limit: completion wins
        step(1'b0, OP_ST, 1'b0, 1'b1, FETCH_RDY, 6, "stl_fetch");
        step(1'b0, OP_ST, 1'b0, 1'b1, DECODE,    6, "stl_decode");
        step(1'b0, OP_ST, 1'b0, 1'b1, EXEC_LS,   6, "stl_exec");
        repeat (4) step(1'b0, OP_ST, 1'b0, 1'b0, MEM_ST, 6, "stl_mem_wait");
        step(1'b0, OP_ST, 1'b0, 1'b1, MEM_ST,    6, "stl_mem_ready");

        // Reset in EXEC aborts: outputs dark, counter cleared, restart at FETCH
        step(1'b0, OP_R, 1'b0, 1'b1, FETCH_RDY, 7, "rr_fetch");
        step(1'b0, OP_R, 1'b0, 1'b1, DECODE,    7, "rr_decode");
        step(1'b1, OP_R, 1'b0, 1'b1, ZERO,      0, "rr_reset_exec");
        step(1'b0, OP_R, 1'b0, 1'b1, FETCH_RDY, 0, "rr_refetch");

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
